// File: rtl/cmd_scheduler_if.sv
// cmd_scheduler_if: requester, datapath and status signals of the command scheduler
interface cmd_scheduler_if #(
    parameter int CMD_W = 32
);
    logic             tr, prf, cfg_done;
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [CMD_W-1:0] req0_data, req1_data, cfg_data;
    logic             cfg_valid, cfg_src, busy, timeout_err;
    modport master (
        output tr, prf, cfg_done, req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, cfg_valid, cfg_data, cfg_src, busy, timeout_err
    );
    modport slave (
        input  tr, prf, cfg_done, req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, cfg_valid, cfg_data, cfg_src, busy, timeout_err
    );
endinterface

// File: rtl/cmd_scheduler.sv
// cmd_scheduler: two-requester command scheduler issuing only inside a quiet tr/prf window
module cmd_scheduler #(
    parameter int CMD_W   = 32,
    parameter int GUARD   = 4,
    parameter int TIMEOUT = 1024
) (
    input logic            clk,
    input logic            rst,
    cmd_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_WIN, ISSUE, WAIT_DONE} state_t;
    state_t           state_q, state_d;
    logic [7:0]       quiet_q, quiet_d;
    logic [1:0]       full_q, full_d;
    logic [CMD_W-1:0] hold0_q, hold0_d, hold1_q, hold1_d, data_q, data_d;
    logic             last_q, last_d, src_q, src_d;
    logic [15:0]      wait_q, wait_d;
    logic             win, grant, take, acc0, acc1, expired;
    // window, round-robin winner, accepts and done-timeout decode
    always_comb begin
        win     = quiet_q == 8'(GUARD);
        grant   = &full_q ? ~last_q : ~full_q[0];
        take    = state_q == WAIT_WIN && win;
        acc0    = bus.req0_valid && !full_q[0];
        acc1    = bus.req1_valid && !full_q[1];
        expired = wait_q == 16'(TIMEOUT - 1);
    end
    // quiet counter, holding slots, grant latch and done-wait counter
    always_comb begin
        quiet_d   = (bus.tr || bus.prf) ? 8'd0 : (win ? quiet_q : quiet_q + 8'd1);
        full_d[0] = (state_q == ISSUE && !src_q) ? 1'b0 : (full_q[0] || acc0);
        full_d[1] = (state_q == ISSUE && src_q) ? 1'b0 : (full_q[1] || acc1);
        hold0_d   = acc0 ? bus.req0_data : hold0_q;
        hold1_d   = acc1 ? bus.req1_data : hold1_q;
        last_d    = take ? grant : last_q;
        src_d     = take ? grant : src_q;
        data_d    = take ? (grant ? hold1_q : hold0_q) : data_q;
        wait_d    = state_q == WAIT_DONE ? wait_q + 16'd1 : 16'd0;
    end
    // FSM next state; cfg_done only matters while waiting for it
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = |full_q ? WAIT_WIN : IDLE;
            WAIT_WIN:  state_d = win ? ISSUE : WAIT_WIN;
            ISSUE:     state_d = WAIT_DONE;
            WAIT_DONE: state_d = (bus.cfg_done || expired) ? IDLE : WAIT_DONE;
            default:   state_d = IDLE;
        endcase
    end
    // outputs; cfg_done beats a same-cycle timeout
    always_comb begin
        bus.req0_ready  = !full_q[0];
        bus.req1_ready  = !full_q[1];
        bus.cfg_valid   = state_q == ISSUE;
        bus.cfg_data    = data_q;
        bus.cfg_src     = src_q;
        bus.busy        = state_q != IDLE;
        bus.timeout_err = state_q == WAIT_DONE && expired && !bus.cfg_done;
    end
    // FSM state register
    always_ff @(posedge clk) begin
        state_q <= rst ? IDLE : state_d;
    end
    // datapath registers; the last-grant pointer resets to 1 so requester 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            quiet_q <= '0;
            full_q  <= '0;
            hold0_q <= '0;
            hold1_q <= '0;
            last_q  <= 1'b1;
            src_q   <= 1'b0;
            data_q  <= '0;
            wait_q  <= '0;
        end else begin
            quiet_q <= quiet_d;
            full_q  <= full_d;
            hold0_q <= hold0_d;
            hold1_q <= hold1_d;
            last_q  <= last_d;
            src_q   <= src_d;
            data_q  <= data_d;
            wait_q  <= wait_d;
        end
    end
endmodule

// File: doc/cmd_scheduler.md
CMD_SCHEDULER -- requirements
Module: cmd_scheduler

Interface
REQ-001 The block SHALL have parameter CMD_W, default 32, meaning command word width in bits.
REQ-002 The block SHALL have parameter GUARD, default 4, meaning consecutive quiet cycles (tr=0 and prf=0) required before issue; legal range 1..255.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, meaning maximum cycles to wait for cfg_done; legal range 2..65535.
REQ-004 The block SHALL have port clk  input  1  single rising-edge clock for all logic.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port tr  input  1  transmit gate; 1 = transmit active.
REQ-007 The block SHALL have port prf  input  1  pulse-repetition strobe; 1 = pulse active.
REQ-008 The block SHALL have ports req0_valid / req1_valid  input  1  requester N offers a command.
REQ-009 The block SHALL have ports req0_data / req1_data  input  CMD_W  command word from requester N.
REQ-010 The block SHALL have ports req0_ready / req1_ready  output  1  requester N holding slot is empty.
REQ-011 The block SHALL have port cfg_valid  output  1  one-cycle issue strobe to the configured datapath.
REQ-012 The block SHALL have port cfg_data  output  CMD_W  issued command word.
REQ-013 The block SHALL have port cfg_src  output  1  index of the requester whose command is issued.
REQ-014 The block SHALL have port cfg_done  input  1  datapath finished applying the command.
REQ-015 The block SHALL have port busy  output  1  state is not IDLE.
REQ-016 The block SHALL have port timeout_err  output  1  one-cycle pulse when cfg_done misses TIMEOUT.

Function
REQ-017 Quiet counter: if tr=0 and prf=0, increment, saturating at GUARD; otherwise clear to 0. window_open SHALL equal (counter == GUARD).
REQ-018 Each requester has a single-entry holding register; reqN_ready SHALL equal NOT full_N (combinational).
REQ-019 Accept: on an edge with reqN_valid=1 and reqN_ready=1, capture reqN_data and set full_N.
REQ-020 full_N SHALL clear on the edge leaving ISSUE when cfg_src=N; reqN_ready rises the following cycle; accept and free never coincide on one slot.
REQ-021 FSM states: IDLE, WAIT_WIN, ISSUE, WAIT_DONE.
REQ-022 IDLE -> WAIT_WIN when full_0 or full_1 is set.
REQ-023 WAIT_WIN -> ISSUE when window_open=1; on that edge, arbitrate, latch the winner's word into cfg_data and its index into cfg_src.
REQ-024 Arbitration is round-robin: with one slot full, grant it; with both full, grant the requester not granted last; the last-grant pointer SHALL update on every grant.
REQ-025 In WAIT_WIN, loss of the quiet condition restarts the counter; the FSM stays in WAIT_WIN and has no timeout there.
REQ-026 ISSUE lasts exactly one cycle with cfg_valid=1, then -> WAIT_DONE; cfg_valid=0 in every other state.
REQ-027 WAIT_DONE: a 16-bit counter starts at 0 and increments each cycle. On cfg_done=1, go to IDLE. If the count reaches TIMEOUT-1 without cfg_done, pulse timeout_err for one cycle and go to IDLE.
REQ-028 cfg_done=1 and timeout in the same cycle: cfg_done wins and timeout_err stays 0. cfg_done outside WAIT_DONE SHALL be ignored.
REQ-029 tr/prf activity during WAIT_DONE SHALL NOT affect it; the datapath owns the window after issue.
REQ-030 cfg_data and cfg_src SHALL hold their last issued values until the next ISSUE.
REQ-031 Latency: with the window already open, cfg_valid is high in the cycle starting 2 edges after the accepting edge.

Reset
REQ-032 Asserting rst SHALL apply on the next clk edge, with this state: IDLE, holdings empty, quiet counter 0, last-grant pointer = 1 (requester 0 wins first), cfg_valid=0, cfg_data=0, cfg_src=0, busy=0, timeout_err=0.
REQ-033 Reset mid-operation SHALL discard pending and in-flight commands without issue; reqN_ready=1 from the first cycle after the reset edge.

Verification
REQ-034 Single request: GUARD=4, tr=prf=0 for 10+ cycles, req0 sends 0xA5A5_0001 -> cfg_valid pulses once, 2 cycles after accept, with cfg_data=0xA5A5_0001 and cfg_src=0; cfg_done 3 cycles later -> busy=0.
REQ-035 Window gating: prf=1 pulses every 3 cycles, pending request -> no cfg_valid; prf held 0 -> cfg_valid exactly 5 cycles after prf falls (4 quiet + issue edge).
REQ-036 Fairness: both slots full with 0x11 (req0) and 0x22 (req1), cfg_done immediate, refill each slot after issue -> issue order 0,1,0,1 with no repeats.
REQ-037 Timeout: TIMEOUT=8, cfg_done never asserted -> timeout_err pulses 8 cycles after ISSUE, FSM returns to IDLE, next pending request issues normally.
REQ-038 Reset in WAIT_DONE with req1 pending -> no cfg_valid after reset, both readys=1, and the next request from req0 is granted first.
